// File: rtl/riscv_pkg.sv
// Shared core-wide types and defaults for the barrel-processed RISC-V core.
package riscv_pkg;
  localparam int NUM_THREADS     = 16;
  localparam int THREAD_ID_WIDTH = $clog2(NUM_THREADS);
  localparam int PC_WIDTH        = 12;
  localparam int ADDR_WIDTH      = PC_WIDTH - 2;

  typedef logic [THREAD_ID_WIDTH-1:0] thread_id_t;
  typedef logic [PC_WIDTH-1:0]        pc_t;

  // Instructions are word aligned; the two low PC bits are always zero.
  function automatic pc_t align_pc(input pc_t pc);
    return {pc[PC_WIDTH-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/riscv_thread_pc_file.sv
// Per-thread PC registers: one async read port, an increment write port and a
// redirect write port that overrides the increment when both hit one thread.
module riscv_thread_pc_file import riscv_pkg::*; #(
  parameter int                  NUM_THREADS  = riscv_pkg::NUM_THREADS,
  parameter int                  PC_WIDTH     = riscv_pkg::PC_WIDTH,
  parameter logic [PC_WIDTH-1:0] STARTUP_ADDR = '0,
  localparam int                 TID_W        = $clog2(NUM_THREADS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [TID_W-1:0]    rd_tid_i,
  output logic [PC_WIDTH-1:0] rd_pc_o,
  input  logic                inc_en_i,
  input  logic [TID_W-1:0]    inc_tid_i,
  input  logic                upd_en_i,
  input  logic [TID_W-1:0]    upd_tid_i,
  input  logic [PC_WIDTH-1:0] upd_pc_i
);
  localparam logic [PC_WIDTH-1:0] RST_PC = {STARTUP_ADDR[PC_WIDTH-1:2], 2'b00};

  logic [NUM_THREADS-1:0][PC_WIDTH-1:0] pc_q, pc_d;

  assign rd_pc_o = pc_q[rd_tid_i];

  always_comb begin
    pc_d = pc_q;
    if (inc_en_i) pc_d[inc_tid_i] = pc_q[inc_tid_i] + PC_WIDTH'(4);
    // Later assignment wins: a redirect beats an increment to the same thread.
    if (upd_en_i) pc_d[upd_tid_i] = {upd_pc_i[PC_WIDTH-1:2], 2'b00};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int t = 0; t < NUM_THREADS; t++) pc_q[t] <= RST_PC;
    end else begin
      pc_q <= pc_d;
    end
  end
endmodule

// File: rtl/riscv_thread_fetch.sv
// Round-robin fetch stage: one thread per cycle drives the instruction BRAM,
// with thread/PC metadata delayed to line up with BRAM read data.
module riscv_thread_fetch import riscv_pkg::*; #(
  parameter int                  NUM_THREADS  = riscv_pkg::NUM_THREADS,
  parameter int                  PC_WIDTH     = riscv_pkg::PC_WIDTH,
  parameter int                  ADDR_WIDTH   = PC_WIDTH - 2,
  parameter logic [PC_WIDTH-1:0] STARTUP_ADDR = '0,
  localparam int                 TID_W        = $clog2(NUM_THREADS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall,
  input  logic [NUM_THREADS-1:0] thread_en,
  input  logic                   upd_valid,
  input  logic [TID_W-1:0]       upd_tid,
  input  logic [PC_WIDTH-1:0]    upd_pc,
  output logic                   imem_en,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  output logic                   if_valid,
  output logic [TID_W-1:0]       if_tid,
  output logic [PC_WIDTH-1:0]    if_pc
);
  logic [TID_W-1:0]      cnt_q, cnt_d;
  logic                  imem_en_q, imem_en_d;
  logic [ADDR_WIDTH-1:0] imem_addr_q, imem_addr_d;
  logic [TID_W-1:0]      s1_tid_q, s1_tid_d;
  logic [PC_WIDTH-1:0]   s1_pc_q, s1_pc_d;
  logic                  if_valid_q, if_valid_d;
  logic [TID_W-1:0]      if_tid_q, if_tid_d;
  logic [PC_WIDTH-1:0]   if_pc_q, if_pc_d;
  logic [PC_WIDTH-1:0]   rd_pc;
  logic                  issue;

  assign issue = !stall && thread_en[cnt_q];

  riscv_thread_pc_file #(
    .NUM_THREADS (NUM_THREADS),
    .PC_WIDTH    (PC_WIDTH),
    .STARTUP_ADDR(STARTUP_ADDR)
  ) u_pc_file (
    .clk      (clk),
    .reset    (reset),
    .rd_tid_i (cnt_q),
    .rd_pc_o  (rd_pc),
    .inc_en_i (issue),
    .inc_tid_i(cnt_q),
    .upd_en_i (upd_valid),
    .upd_tid_i(upd_tid),
    .upd_pc_i (upd_pc)
  );

  always_comb begin
    cnt_d       = cnt_q;
    imem_en_d   = issue;
    imem_addr_d = imem_addr_q;
    s1_tid_d    = s1_tid_q;
    s1_pc_d     = s1_pc_q;
    if_valid_d  = if_valid_q;
    if_tid_d    = if_tid_q;
    if_pc_d     = if_pc_q;
    if (!stall) begin
      // Power-of-two thread count: natural overflow is the round-robin wrap.
      cnt_d      = cnt_q + TID_W'(1);
      s1_tid_d   = cnt_q;
      s1_pc_d    = rd_pc;
      if_valid_d = imem_en_q;
      if_tid_d   = s1_tid_q;
      if_pc_d    = s1_pc_q;
      if (issue) imem_addr_d = rd_pc[ADDR_WIDTH+1:2];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q       <= '0;
      imem_en_q   <= 1'b0;
      imem_addr_q <= '0;
      s1_tid_q    <= '0;
      s1_pc_q     <= '0;
      if_valid_q  <= 1'b0;
      if_tid_q    <= '0;
      if_pc_q     <= '0;
    end else begin
      cnt_q       <= cnt_d;
      imem_en_q   <= imem_en_d;
      imem_addr_q <= imem_addr_d;
      s1_tid_q    <= s1_tid_d;
      s1_pc_q     <= s1_pc_d;
      if_valid_q  <= if_valid_d;
      if_tid_q    <= if_tid_d;
      if_pc_q     <= if_pc_d;
    end
  end

  assign imem_en   = imem_en_q;
  assign imem_addr = imem_addr_q;
  assign if_valid  = if_valid_q;
  assign if_tid    = if_tid_q;
  assign if_pc     = if_pc_q;
endmodule

// File: tb/tb_riscv_thread_fetch.sv
// Scoreboarded bench for riscv_thread_fetch: directed scenarios then random traffic.
module tb_riscv_thread_fetch;
  import riscv_pkg::*;
  localparam int NT = 16;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            stall = 1'b0;
  logic [NT-1:0]   thread_en = '1;
  logic            upd_valid = 1'b0;
  thread_id_t      upd_tid = '0;
  pc_t             upd_pc = '0;
  logic            imem_en;
  logic [9:0]      imem_addr;
  logic            if_valid;
  thread_id_t      if_tid;
  pc_t             if_pc;

  always #5 clk = ~clk;

  riscv_thread_fetch dut (
    .clk(clk), .reset(reset), .stall(stall), .thread_en(thread_en),
    .upd_valid(upd_valid), .upd_tid(upd_tid), .upd_pc(upd_pc),
    .imem_en(imem_en), .imem_addr(imem_addr),
    .if_valid(if_valid), .if_tid(if_tid), .if_pc(if_pc)
  );

  typedef struct packed { thread_id_t tid; pc_t pc; } fetch_t;

  int checks = 0;
  int failures = 0;

  // Reference state: one PC per thread, a round-robin pointer, and what the
  // BRAM port / fetch outputs should show this cycle.
  pc_t        m_pc [NT];
  int         m_cnt = 0;
  bit         m_en = 1'b0;
  logic [9:0] m_addr = '0;
  bit         m_ifv = 1'b0;
  bit         fresh = 1'b0;
  fetch_t     sbq [$];

  pc_t        obs_pc [NT];
  int         obs_n [NT];
  int         obs_tids [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int cur;
    if (reset) begin
      m_cnt = 0;
      for (int t = 0; t < NT; t++) m_pc[t] = 12'h000;
      m_en = 0; m_addr = '0; m_ifv = 0; fresh = 0;
      sbq.delete();
      return;
    end
    fresh = !stall;
    if (!stall) begin
      m_ifv = m_en;
    end else if (m_en) begin
      void'(sbq.pop_back());   // issued last cycle, lost to the freeze
    end
    if (!stall) begin
      cur   = m_cnt;
      m_cnt = (m_cnt + 1) % NT;
      if (thread_en[cur]) begin
        m_en   = 1;
        m_addr = m_pc[cur] / 4;
        sbq.push_back('{tid: thread_id_t'(cur), pc: m_pc[cur]});
        m_pc[cur] = m_pc[cur] + 12'd4;
      end else begin
        m_en = 0;
      end
    end else begin
      m_en = 0;
    end
    if (upd_valid) m_pc[upd_tid] = upd_pc & 12'hFFC;
  endtask

  initial forever begin
    @(posedge clk or posedge reset);
    model_step();
  end

  task automatic monitor_step();
    fetch_t e;
    chk("imem_en", 32'(imem_en), 32'(m_en));
    chk("imem_addr", 32'(imem_addr), 32'(m_addr));
    chk("if_valid", 32'(if_valid), 32'(m_ifv));
    if (fresh && if_valid && m_ifv) begin
      if (sbq.size() == 0) begin
        checks++; failures++;
        $display("FAIL sb_underflow: got tid %0d pc %0h expected nothing", if_tid, if_pc);
      end else begin
        e = sbq.pop_front();
        chk("if_tid", 32'(if_tid), 32'(e.tid));
        chk("if_pc", 32'(if_pc), 32'(e.pc));
        obs_pc[if_tid] = if_pc;
        obs_n[if_tid]++;
        obs_tids.push_back(int'(if_tid));
      end
    end
  endtask

  initial forever begin
    @(negedge clk);
    monitor_step();
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic run_until_cnt(input int k);
    int n = 0;
    while (m_cnt != k && n < 40) begin cyc(); n++; end
    if (m_cnt != k) begin
      checks++; failures++;
      $display("FAIL wait_cnt: got %0d expected %0d", m_cnt, k);
    end
  endtask

  initial begin
    pc_t old7;
    for (int t = 0; t < NT; t++) begin obs_pc[t] = '0; obs_n[t] = 0; end
    #1 reset = 1'b1;
    repeat (3) cyc();
    reset = 1'b0;
    repeat (40) cyc();

    // Redirect thread 5 while thread 3 issues.
    run_until_cnt(3);
    upd_valid = 1; upd_tid = 4'd5; upd_pc = 12'h100;
    cyc();
    upd_valid = 0;
    repeat (5) cyc();
    chk("redir5_pc", 32'(obs_pc[5]), 32'h100);

    // Redirect thread 7 in its own issue cycle: old PC fetched, redirect stored.
    run_until_cnt(7);
    old7 = m_pc[7];
    upd_valid = 1; upd_tid = 4'd7; upd_pc = 12'h203;
    cyc();
    upd_valid = 0;
    repeat (2) cyc();
    chk("redir7_oldfetch", 32'(obs_pc[7]), 32'(old7));
    repeat (18) cyc();
    chk("redir7_newfetch", 32'(obs_pc[7]), 32'h200);

    // PC wrap at the top of the address space.
    run_until_cnt(2);
    upd_valid = 1; upd_tid = 4'd0; upd_pc = 12'hFFC;
    cyc();
    upd_valid = 0;
    run_until_cnt(0);
    repeat (3) cyc();
    chk("wrap_ffc", 32'(obs_pc[0]), 32'hFFC);
    repeat (16) cyc();
    chk("wrap_zero", 32'(obs_pc[0]), 32'h000);

    // Three-cycle stall at thread 9; thread 9 must be first out afterwards.
    run_until_cnt(9);
    obs_tids.delete();
    stall = 1;
    repeat (3) cyc();
    chk("stall_imem_en", 32'(imem_en), 32'h0);
    stall = 0;
    repeat (4) cyc();
    if (obs_tids.size() == 0) begin
      checks++; failures++;
      $display("FAIL stall_resume: got no fetch expected tid 9");
    end else begin
      chk("stall_resume_tid", 32'(obs_tids[0]), 32'd9);
    end

    // Thread 0 masked after reset: no fetches and its PC stays at startup.
    reset = 1;
    cyc();
    reset = 0;
    thread_en = 16'hFFFE;
    for (int t = 0; t < NT; t++) obs_n[t] = 0;
    obs_pc[0] = 12'hABC;
    repeat (40) cyc();
    chk("masked_t0_count", 32'(obs_n[0]), 32'd0);
    thread_en = '1;
    run_until_cnt(0);
    repeat (3) cyc();
    chk("masked_t0_pc", 32'(obs_pc[0]), 32'h000);

    // Asynchronous reset between clock edges.
    repeat (5) cyc();
    #2 reset = 1;
    #1;
    chk("areset_imem_en", 32'(imem_en), 32'h0);
    chk("areset_imem_addr", 32'(imem_addr), 32'h0);
    chk("areset_if_valid", 32'(if_valid), 32'h0);
    chk("areset_if_tid", 32'(if_tid), 32'h0);
    chk("areset_if_pc", 32'(if_pc), 32'h0);
    cyc();
    reset = 0;

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      stall     = ($urandom_range(7) == 0);
      thread_en = NT'($urandom | $urandom);
      upd_valid = ($urandom_range(3) == 0);
      upd_tid   = thread_id_t'($urandom);
      upd_pc    = pc_t'($urandom);
      reset     = ($urandom_range(499) == 0);
      cyc();
    end
    reset = 0; stall = 0; upd_valid = 0; thread_en = '0;
    repeat (4) cyc();
    chk("sb_drain", 32'(sbq.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
